// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART transmit arbiter.
// The arbiter attaches through the slave modport; producers/transmitter use master.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned IdW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_last;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         txbyte;
    logic               senddata;
    logic               txdone;
    logic [IdW-1:0]     grant_id;
    logic               locked;
    logic               busy;

    modport master (
        output req_valid, req_last, req_data, txdone,
        input  req_ready, txbyte, senddata, grant_id, locked, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, txdone,
        output req_ready, txbyte, senddata, grant_id, locked, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N_REQ byte streams,
// keeping multi-byte messages contiguous and forcing idle after each frame and after reset.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned GUARD_CYCLES = 2604,
    parameter int unsigned RESET_HOLD   = 28644
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned    IdW    = $clog2(N_REQ);
    localparam logic [IdW:0]   NumReq = (IdW+1)'(N_REQ);
    localparam logic [IdW-1:0] LastId = IdW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StWaitDone, StGuard} state_e;

    state_e             state_q, state_d;
    logic [31:0]        guard_cnt_q, guard_cnt_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic               locked_q, locked_d;
    logic [7:0]         txbyte_q, txbyte_d;
    logic               senddata_q, senddata_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;

    logic               win_found;
    logic [IdW-1:0]     win_id;
    logic [IdW:0]       cand;
    logic [7:0]         win_data;
    logic               win_last;

    // Winner selection: an open message only ever serves its owner.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr_q;
        cand      = '0;
        if (locked_q) begin
            win_found = bus.req_valid[grant_id_q];
            win_id    = grant_id_q;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                cand = {1'b0, rr_ptr_q} + k[IdW:0];
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                if (!win_found && bus.req_valid[cand[IdW-1:0]]) begin
                    win_found = 1'b1;
                    win_id    = cand[IdW-1:0];
                end
            end
        end
        win_data = bus.req_data[{win_id, 3'b000} +: 8];
        win_last = bus.req_last[win_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (RESET_HOLD == 0) ? StIdle : StGuard;
            guard_cnt_q <= 32'(RESET_HOLD);
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            locked_q    <= 1'b0;
            txbyte_q    <= 8'h00;
            senddata_q  <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            locked_q    <= locked_d;
            txbyte_q    <= txbyte_d;
            senddata_q  <= senddata_d;
            req_ready_q <= req_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        locked_d    = locked_q;
        txbyte_d    = txbyte_q;
        senddata_d  = 1'b0;
        req_ready_d = '0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    txbyte_d            = win_data;
                    senddata_d          = 1'b1;
                    req_ready_d[win_id] = 1'b1;
                    grant_id_d          = win_id;
                    locked_d            = ~win_last;
                    if (win_last) begin
                        rr_ptr_d = (win_id == LastId) ? '0 : win_id + IdW'(1);
                    end
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (bus.txdone) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        guard_cnt_d = 32'(GUARD_CYCLES);
                        state_d     = StGuard;
                    end
                end
            end
            StGuard: begin
                // txdone is deliberately ignored here so a stray pulse cannot shorten the guard.
                guard_cnt_d = guard_cnt_q - 32'd1;
                if (guard_cnt_q <= 32'd1) begin
                    guard_cnt_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready = req_ready_q;
        bus.txbyte    = txbyte_q;
        bus.senddata  = senddata_q;
        bus.grant_id  = grant_id_q;
        bus.locked    = locked_q;
        bus.busy      = (state_q != StIdle);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for grant order, guard length and reset behaviour.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int G     = 3;
    localparam int RH    = 5;
    localparam int FRAME = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tx_auto = 1'b0;
    logic tx_spur = 1'b0;
    bit   chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ       (N),
        .GUARD_CYCLES(G),
        .RESET_HOLD  (RH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.txdone = tx_auto | tx_spur;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requesters: per-requester byte FIFOs, head presented until its ready pulse.
    logic [8:0] tbl [N][16];
    int head [N];
    int tail [N];

    task automatic push(input int i, input logic [7:0] d, input logic l);
        tbl[i][tail[i] & 15] = {l, d};
        tail[i]++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] === 1'b1 && head[i] != tail[i]) head[i]++;
                if (head[i] != tail[i]) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = tbl[i][head[i] & 15][7:0];
                    bus.req_last[i]        = tbl[i][head[i] & 15][8];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Transmitter stand-in: txdone FRAME cycles after each senddata.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.senddata === 1'b1) begin
                repeat (FRAME - 1) @(posedge clk);
                #1 tx_auto = 1'b1;
                @(posedge clk);
                #1 tx_auto = 1'b0;
            end
        end
    end

    // Behavioural model: a byte is in flight until txdone, then G idle cycles must elapse.
    int         m_cool;
    bit         m_inflight;
    bit         m_lock;
    int         m_gid;
    int         m_next;
    logic [7:0] m_txbyte;
    logic       m_send;
    logic [N-1:0] m_ready;

    function automatic int pick();
        int best;
        int bd;
        best = -1;
        bd   = N;
        if (m_lock) return (bus.req_valid[m_gid] === 1'b1) ? m_gid : -1;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] === 1'b1 && (i - m_next + N) % N < bd) begin
                bd   = (i - m_next + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cool     <= RH;
            m_inflight <= 1'b0;
            m_lock     <= 1'b0;
            m_gid      <= 0;
            m_next     <= 0;
            m_txbyte   <= 8'h00;
            m_send     <= 1'b0;
            m_ready    <= '0;
        end else begin
            m_send  <= 1'b0;
            m_ready <= '0;
            if (m_inflight) begin
                if (bus.txdone === 1'b1) begin
                    m_inflight <= 1'b0;
                    m_cool     <= G;
                end
            end else if (m_cool > 0) begin
                m_cool <= m_cool - 1;
            end else if (pick() >= 0) begin
                m_txbyte   <= bus.req_data[8*pick() +: 8];
                m_send     <= 1'b1;
                m_ready    <= 4'(1) << pick();
                m_gid      <= pick();
                m_lock     <= !bus.req_last[pick()];
                if (bus.req_last[pick()]) m_next <= (pick() + 1) % N;
                m_inflight <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", {bus.req_ready, bus.senddata, bus.txbyte, bus.grant_id, bus.locked,
                            bus.busy},
                  {m_ready, m_send, m_txbyte, m_gid[1:0], m_lock,
                   (m_inflight || m_cool != 0)});
        end
    end

    // Grant log taken from the wire for the literal order checks.
    int         gq [$];
    logic [7:0] bq [$];
    logic [N-1:0] rq [$];

    always @(negedge clk) begin
        if (chk_en && bus.senddata === 1'b1) begin
            gq.push_back(int'(bus.grant_id));
            bq.push_back(bus.txbyte);
            rq.push_back(bus.req_ready);
        end
    end

    task automatic clear_log();
        gq.delete();
        bq.delete();
        rq.delete();
    endtask

    task automatic wait_grants(input int n, input string name);
        int k;
        k = 0;
        while (gq.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_grants"}, gq.size(), n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", bus.busy, 0);
        @(negedge clk);
    endtask

    task automatic guard_len(input bit spur, output int n);
        int k;
        k = 0;
        n = 0;
        while (tx_auto !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("txdone_wait", tx_auto, 1);
        @(negedge clk);
        if (spur) tx_spur = 1'b1;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            tx_spur = 1'b0;
        end
        tx_spur = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_senddata", bus.senddata, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_locked", bus.locked, 0);
        check("rst_txbyte", bus.txbyte, 8'h00);
        check("rst_grant", bus.grant_id, 0);
        check("rst_ready", bus.req_ready, 0);

        // Reset hold: requester 0 waits out RH guard cycles, served on the next edge.
        push(0, 8'hA5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < RH; k++) begin
            @(posedge clk);
            #1 check("hold_quiet", bus.senddata, 0);
        end
        @(posedge clk);
        #1;
        check("hold_send", bus.senddata, 1);
        check("hold_byte", bus.txbyte, 8'hA5);

        // Single byte from requester 2.
        wait_idle();
        clear_log();
        push(2, 8'h41, 1'b1);
        wait_grants(1, "single");
        check("single_gid", gq[0], 2);
        check("single_byte", bq[0], 8'h41);
        check("single_ready", rq[0], 4'b0100);
        guard_len(1'b0, n);
        check("single_guard", n, G);

        // rr_ptr is 3 after the grant to 2.
        wait_idle();
        clear_log();
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
        wait_grants(4, "rr_a");
        check("rr_a0", gq[0], 3);
        check("rr_a1", gq[1], 0);
        check("rr_a2", gq[2], 1);
        check("rr_a3", gq[3], 2);
        check("rr_a_byte0", bq[0], 8'h13);

        wait_idle();
        push(3, 8'h23, 1'b1);
        wait_grants(5, "rr_wrap");
        check("rr_wrap_gid", gq[4], 3);

        wait_idle();
        clear_log();
        for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i), 1'b1);
        push(0, 8'h14, 1'b1);
        wait_grants(5, "rr_b");
        check("rr_b0", gq[0], 0);
        check("rr_b1", gq[1], 1);
        check("rr_b2", gq[2], 2);
        check("rr_b3", gq[3], 3);
        check("rr_b4", gq[4], 0);
        check("rr_b4_byte", bq[4], 8'h14);

        // Message lock: requester 1 owns the wire for both of its bytes.
        wait_idle();
        clear_log();
        push(1, 8'h48, 1'b0);
        push(1, 8'h49, 1'b1);
        push(0, 8'hB0, 1'b1);
        wait_grants(1, "lock_first");
        check("lock_open", bus.locked, 1);
        wait_grants(3, "lock");
        check("lock_b0", bq[0], 8'h48);
        check("lock_b1", bq[1], 8'h49);
        check("lock_b2", bq[2], 8'hB0);

        // Reset in the middle of a message.
        wait_idle();
        clear_log();
        push(1, 8'h60, 1'b0);
        push(1, 8'h61, 1'b1);
        push(0, 8'h70, 1'b1);
        wait_grants(1, "mid_first");
        check("mid_gid", gq[0], 1);
        check("mid_locked_pre", bus.locked, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_locked", bus.locked, 0);
        check("mid_senddata", bus.senddata, 0);
        check("mid_txbyte", bus.txbyte, 8'h00);
        check("mid_grant", bus.grant_id, 0);
        check("mid_busy", bus.busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grants(3, "mid_after");
        check("mid_after0_gid", gq[1], 0);
        check("mid_after0_byte", bq[1], 8'h70);
        check("mid_after1_gid", gq[2], 1);
        check("mid_after1_byte", bq[2], 8'h61);

        // Spurious txdone in IDLE and during the guard.
        wait_idle();
        clear_log();
        tx_spur = 1'b1;
        @(negedge clk);
        tx_spur = 1'b0;
        @(negedge clk);
        check("spur_idle_busy", bus.busy, 0);
        check("spur_idle_sends", gq.size(), 0);
        push(2, 8'h5A, 1'b1);
        wait_grants(1, "spur");
        guard_len(1'b1, n);
        check("spur_guard", n, G);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
